ir_nec_frame_decoder: RTL and testbench

- Parametrised NEC-protocol IR frame decoder that samples the raw receiver pin directly, replacing the fixed 24-bit decoder that relied on external mark/space counters.
- Internally measures mark/space widths with a prescaled tick timer and validates each against tolerance windows.
- Captures NBITS data bits (LSB first), detects repeat frames, checks command inversion, and flags malformed frames.
- Sits between the IR receiver pin and the display/control logic that consumes key codes.

---
 rtl/ir_nec_pkg.sv | 38 +++
 rtl/ir_nec_frame_decoder_if.sv | 21 ++
 rtl/ir_pulse_timer.sv | 58 +++++
 rtl/ir_nec_frame_decoder.sv | 152 +++++++++++++++
 tb/tb_ir_nec_frame_decoder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ir_nec_pkg.sv
// Shared NEC decoder definitions: FSM states, timing windows (in prescaled
// ticks of 1/10 NEC unit) and the window-compare helper.
package ir_nec_pkg;

  localparam int DUR_W = 8;
  localparam logic [DUR_W-1:0] DUR_MAX = DUR_W'(255);
  localparam logic [DUR_W-1:0] TIMEOUT_TICKS = DUR_W'(200);

  localparam logic [DUR_W-1:0] LDR_MARK_MIN  = DUR_W'(144);
  localparam logic [DUR_W-1:0] LDR_MARK_MAX  = DUR_W'(176);
  localparam logic [DUR_W-1:0] LDR_SPACE_MIN = DUR_W'(72);
  localparam logic [DUR_W-1:0] LDR_SPACE_MAX = DUR_W'(88);
  localparam logic [DUR_W-1:0] RPT_SPACE_MIN = DUR_W'(32);
  localparam logic [DUR_W-1:0] RPT_SPACE_MAX = DUR_W'(48);
  localparam logic [DUR_W-1:0] BIT_MARK_MIN  = DUR_W'(7);
  localparam logic [DUR_W-1:0] BIT_MARK_MAX  = DUR_W'(13);
  localparam logic [DUR_W-1:0] ZERO_SPACE_MIN = DUR_W'(7);
  localparam logic [DUR_W-1:0] ZERO_SPACE_MAX = DUR_W'(13);
  localparam logic [DUR_W-1:0] ONE_SPACE_MIN  = DUR_W'(25);
  localparam logic [DUR_W-1:0] ONE_SPACE_MAX  = DUR_W'(35);

  typedef enum logic [2:0] {
    IDLE,
    LDR_MARK,
    LDR_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    RPT_STOP
  } ir_state_t;

  function automatic logic in_window(input logic [DUR_W-1:0] d,
                                     input logic [DUR_W-1:0] lo,
                                     input logic [DUR_W-1:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/ir_nec_frame_decoder_if.sv
// Decoder-facing bundle: raw receiver pin in, key code and event pulses out.
interface ir_nec_frame_decoder_if #(
  parameter int NBITS = 32
);
  logic             ir_in;
  logic [NBITS-1:0] code;
  logic             code_valid;
  logic             repeat_valid;
  logic             frame_err;
  logic             busy;

  modport master (
    input  ir_in,
    output code, code_valid, repeat_valid, frame_err, busy
  );

  modport slave (
    output ir_in,
    input  code, code_valid, repeat_valid, frame_err, busy
  );
endinterface

// File: rtl/ir_pulse_timer.sv
// Synchronises the raw IR pin, normalises it to mark=1 and measures how long
// each level lasted in prescaled ticks.
module ir_pulse_timer
  import ir_nec_pkg::*;
#(
  parameter int TICK_DIV      = 2812,
  parameter int IR_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             reset_N,
  input  logic             ir_in,
  output logic             mark_lvl,
  output logic             lvl_edge,
  output logic [DUR_W-1:0] dur
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic INACTIVE = (IR_ACTIVE_LOW != 0);

  logic          sync1;
  logic          sync_q;
  logic          prev_q;
  logic [PW-1:0] presc;
  logic [DUR_W-1:0] cnt;
  logic          tick;

  assign tick     = (presc == PW'(TICK_DIV - 1));
  assign lvl_edge = (sync_q != prev_q);
  assign mark_lvl = sync_q ^ INACTIVE;
  assign dur      = cnt;

  // The count is read on the edge cycle before it clears, so it reports the level that just ended.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      sync1  <= INACTIVE;
      sync_q <= INACTIVE;
      prev_q <= INACTIVE;
      presc  <= '0;
      cnt    <= '0;
    end else begin
      sync1  <= ir_in;
      sync_q <= sync1;
      prev_q <= sync_q;
      if (lvl_edge) begin
        presc <= '0;
        cnt   <= '0;
      end else if (tick) begin
        presc <= '0;
        if (cnt != DUR_MAX) begin
          cnt <= cnt + DUR_W'(1);
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/ir_nec_frame_decoder.sv
// NEC IR frame decoder: validates leader, data bits and stop mark straight
// from the receiver pin, delivering key codes, repeat pulses and frame errors.
module ir_nec_frame_decoder
  import ir_nec_pkg::*;
#(
  parameter int TICK_DIV      = 2812,
  parameter int NBITS         = 32,
  parameter int CHECK_INV     = 1,
  parameter int IR_ACTIVE_LOW = 1
) (
  input logic                    clk,
  input logic                    reset_N,
  ir_nec_frame_decoder_if.master bus
);

  localparam int IW = $clog2(NBITS);

  logic             mark_lvl;
  logic             lvl_edge;
  logic [DUR_W-1:0] dur;

  ir_state_t        state;
  logic [NBITS-1:0] shift;
  logic [IW-1:0]    bit_idx;
  logic [NBITS-1:0] code_q;
  logic             has_code;
  logic             code_valid_q;
  logic             repeat_valid_q;
  logic             frame_err_q;

  logic ldr_mark_ok, ldr_space_ok, rpt_space_ok, bit_mark_ok, zero_ok, one_ok;
  logic inv_ok;

  ir_pulse_timer #(
    .TICK_DIV      (TICK_DIV),
    .IR_ACTIVE_LOW (IR_ACTIVE_LOW)
  ) u_timer (
    .clk      (clk),
    .reset_N  (reset_N),
    .ir_in    (bus.ir_in),
    .mark_lvl (mark_lvl),
    .lvl_edge (lvl_edge),
    .dur      (dur)
  );

  assign ldr_mark_ok  = in_window(dur, LDR_MARK_MIN, LDR_MARK_MAX);
  assign ldr_space_ok = in_window(dur, LDR_SPACE_MIN, LDR_SPACE_MAX);
  assign rpt_space_ok = in_window(dur, RPT_SPACE_MIN, RPT_SPACE_MAX);
  assign bit_mark_ok  = in_window(dur, BIT_MARK_MIN, BIT_MARK_MAX);
  assign zero_ok      = in_window(dur, ZERO_SPACE_MIN, ZERO_SPACE_MAX);
  assign one_ok       = in_window(dur, ONE_SPACE_MIN, ONE_SPACE_MAX);

  // Command byte must arrive alongside its complement on full-length frames.
  generate
    if (NBITS == 32 && CHECK_INV != 0) begin : g_inv
      assign inv_ok = (shift[31:24] == ~shift[23:16]);
    end else begin : g_noinv
      assign inv_ok = 1'b1;
    end
  endgenerate

  // An edge always takes priority over the idle timeout in the same cycle.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state          <= IDLE;
      shift          <= '0;
      bit_idx        <= '0;
      code_q         <= '0;
      has_code       <= 1'b0;
      code_valid_q   <= 1'b0;
      repeat_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      code_valid_q   <= 1'b0;
      repeat_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
      if (lvl_edge) begin
        unique case (state)
          IDLE: begin
            if (mark_lvl) state <= LDR_MARK;
          end
          LDR_MARK: begin
            if (ldr_mark_ok) begin
              state <= LDR_SPACE;
            end else begin
              frame_err_q <= 1'b1;
              state       <= IDLE;
            end
          end
          LDR_SPACE: begin
            if (ldr_space_ok) begin
              state   <= BIT_MARK;
              bit_idx <= '0;
            end else if (rpt_space_ok) begin
              state <= RPT_STOP;
            end else begin
              frame_err_q <= 1'b1;
              state       <= IDLE;
            end
          end
          BIT_MARK: begin
            if (bit_mark_ok) begin
              state <= BIT_SPACE;
            end else begin
              frame_err_q <= 1'b1;
              state       <= IDLE;
            end
          end
          BIT_SPACE: begin
            if (zero_ok || one_ok) begin
              shift   <= {one_ok, shift[NBITS-1:1]};
              bit_idx <= bit_idx + IW'(1);
              state   <= (bit_idx == IW'(NBITS - 1)) ? STOP_MARK : BIT_MARK;
            end else begin
              frame_err_q <= 1'b1;
              state       <= IDLE;
            end
          end
          STOP_MARK: begin
            if (bit_mark_ok && inv_ok) begin
              code_q       <= shift;
              code_valid_q <= 1'b1;
              has_code     <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state <= IDLE;
          end
          RPT_STOP: begin
            if (bit_mark_ok && has_code) begin
              repeat_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && dur >= TIMEOUT_TICKS) begin
        frame_err_q <= 1'b1;
        state       <= IDLE;
      end
    end
  end

  assign bus.code         = code_q;
  assign bus.code_valid   = code_valid_q;
  assign bus.repeat_valid = repeat_valid_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_ir_nec_frame_decoder.sv
// Directed bench for the NEC decoder: table of whole frames plus hand-built
// sequences for window edges, timeout and reset corner cases.
`timescale 1ns/1ps
module tb_ir_nec_frame_decoder;

  localparam int TD = 4;

  typedef enum int {EXP_CODE, EXP_RPT, EXP_ERR} expKind_t;

  typedef struct {
    string       name;
    int          dut;
    int          ldrMark;
    int          ldrSpace;
    bit          rpt;
    logic [31:0] data;
    int          nbits;
    int          markT;
    int          zeroT;
    int          oneT;
    expKind_t    kind;
    logic [31:0] expCode;
  } frameVec_t;

  logic clk = 1'b0;
  logic reset_N = 1'b0;
  logic irMark = 1'b0;
  int   sel = 0;
  int   checks = 0;
  int   errors = 0;
  int   cvCnt[3] = '{0, 0, 0};
  int   rvCnt[3] = '{0, 0, 0};
  int   feCnt[3] = '{0, 0, 0};

  always #5 clk = ~clk;

  ir_nec_frame_decoder_if #(.NBITS(32)) busA ();
  ir_nec_frame_decoder_if #(.NBITS(32)) busB ();
  ir_nec_frame_decoder_if #(.NBITS(16)) busC ();

  // Receivers are active low; an unselected decoder just sees an idle line.
  assign busA.ir_in = (sel == 0) ? ~irMark : 1'b1;
  assign busB.ir_in = (sel == 1) ? ~irMark : 1'b1;
  assign busC.ir_in = (sel == 2) ? ~irMark : 1'b1;

  ir_nec_frame_decoder #(.TICK_DIV(TD), .NBITS(32), .CHECK_INV(1), .IR_ACTIVE_LOW(1)) dutA (
    .clk(clk), .reset_N(reset_N), .bus(busA.master));
  ir_nec_frame_decoder #(.TICK_DIV(TD), .NBITS(32), .CHECK_INV(0), .IR_ACTIVE_LOW(1)) dutB (
    .clk(clk), .reset_N(reset_N), .bus(busB.master));
  ir_nec_frame_decoder #(.TICK_DIV(TD), .NBITS(16), .CHECK_INV(1), .IR_ACTIVE_LOW(1)) dutC (
    .clk(clk), .reset_N(reset_N), .bus(busC.master));

  logic [2:0]  cvV, rvV, feV, byV;
  logic [31:0] codeV [3];
  assign cvV = {busC.code_valid, busB.code_valid, busA.code_valid};
  assign rvV = {busC.repeat_valid, busB.repeat_valid, busA.repeat_valid};
  assign feV = {busC.frame_err, busB.frame_err, busA.frame_err};
  assign byV = {busC.busy, busB.busy, busA.busy};
  assign codeV[0] = busA.code;
  assign codeV[1] = busB.code;
  assign codeV[2] = {16'h0000, busC.code};

  // Pulse tally per decoder, used to prove no stray events inside a frame.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (cvV[i]) cvCnt[i]++;
      if (rvV[i]) rvCnt[i]++;
      if (feV[i]) feCnt[i]++;
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic frameVec_t mkVec(string name, int dut, int lm, int ls, bit rpt,
                                      logic [31:0] data, int nbits, int mt, int zt, int ot,
                                      expKind_t kind, logic [31:0] expCode);
    frameVec_t v;
    v.name = name; v.dut = dut; v.ldrMark = lm; v.ldrSpace = ls; v.rpt = rpt;
    v.data = data; v.nbits = nbits; v.markT = mt; v.zeroT = zt; v.oneT = ot;
    v.kind = kind; v.expCode = expCode;
    return v;
  endfunction

  function automatic logic getPulse(int d, expKind_t k);
    case (k)
      EXP_CODE: return cvV[d];
      EXP_RPT:  return rvV[d];
      default:  return feV[d];
    endcase
  endfunction

  task automatic checkOutput(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Levels run half a tick long so the measured count is insensitive to prescaler phase.
  task automatic holdLevel(input logic lvl, input int ticks);
    irMark = lvl;
    repeat (ticks * TD + TD / 2) @(negedge clk);
  endtask

  task automatic applyStimulus(input frameVec_t v);
    sel = v.dut;
    holdLevel(1'b1, v.ldrMark);
    holdLevel(1'b0, v.ldrSpace);
    if (!v.rpt) begin
      for (int i = 0; i < v.nbits; i++) begin
        holdLevel(1'b1, v.markT);
        holdLevel(1'b0, v.data[i] ? v.oneT : v.zeroT);
      end
    end
    holdLevel(1'b1, v.markT);
    irMark = 1'b0;
  endtask

  // The event must appear on exactly the lat-th clock after the last line change.
  task automatic checkLatency(input int d, input expKind_t k, input int lat, input string name);
    for (int j = 1; j <= lat + 1; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == lat - 1) begin
        checkOutput({name, " early pulse"}, 32'(getPulse(d, k)), 32'd0);
        checkOutput({name, " busy before"}, 32'(byV[d]), 32'd1);
      end else if (j == lat) begin
        checkOutput({name, " pulse"}, 32'(getPulse(d, k)), 32'd1);
        checkOutput({name, " busy after"}, 32'(byV[d]), 32'd0);
      end else if (j == lat + 1) begin
        checkOutput({name, " pulse width"}, 32'(getPulse(d, k)), 32'd0);
      end
    end
  endtask

  task automatic runVector(input frameVec_t v);
    int c0, r0, f0;
    c0 = cvCnt[v.dut];
    r0 = rvCnt[v.dut];
    f0 = feCnt[v.dut];
    applyStimulus(v);
    checkLatency(v.dut, v.kind, 3, v.name);
    checkOutput({v.name, " code_valid count"}, 32'(cvCnt[v.dut] - c0), 32'(v.kind == EXP_CODE));
    checkOutput({v.name, " repeat_valid count"}, 32'(rvCnt[v.dut] - r0), 32'(v.kind == EXP_RPT));
    checkOutput({v.name, " frame_err count"}, 32'(feCnt[v.dut] - f0), 32'(v.kind == EXP_ERR));
    checkOutput({v.name, " code"}, codeV[v.dut], v.expCode);
    holdLevel(1'b0, 20);
  endtask

  initial begin
    frameVec_t vecs[8];
    frameVec_t v;
    int c0;

    vecs[0] = mkVec("rptNoCode",  0, 160, 40, 1'b1, 32'h0,        32, 10, 10, 30, EXP_ERR,  32'h0);
    vecs[1] = mkVec("goodFrame",  0, 160, 80, 1'b0, 32'hF708FB04, 32, 10, 10, 30, EXP_CODE, 32'hF708FB04);
    vecs[2] = mkVec("repeat",     0, 160, 40, 1'b1, 32'h0,        32, 10, 10, 30, EXP_RPT,  32'hF708FB04);
    vecs[3] = mkVec("badInv",     0, 160, 80, 1'b0, 32'hF608FB04, 32, 10, 10, 30, EXP_ERR,  32'hF708FB04);
    vecs[4] = mkVec("noInvCheck", 1, 160, 80, 1'b0, 32'hF608FB04, 32, 10, 10, 30, EXP_CODE, 32'hF608FB04);
    vecs[5] = mkVec("ldr144",     0, 144, 80, 1'b0, 32'hA55AED12, 32,  7, 13, 25, EXP_CODE, 32'hA55AED12);
    vecs[6] = mkVec("ldr176",     0, 176, 72, 1'b0, 32'h00FF00FF, 32, 13,  7, 35, EXP_CODE, 32'h00FF00FF);
    vecs[7] = mkVec("n16Frame",   2, 160, 88, 1'b0, 32'h0000BEEF, 16, 10, 10, 30, EXP_CODE, 32'h0000BEEF);

    repeat (4) @(negedge clk);
    checkOutput("reset code", codeV[0], 32'h0);
    checkOutput("reset code_valid", 32'(cvV[0]), 32'd0);
    checkOutput("reset repeat_valid", 32'(rvV[0]), 32'd0);
    checkOutput("reset frame_err", 32'(feV[0]), 32'd0);
    checkOutput("reset busy", 32'(byV), 32'd0);
    reset_N = 1'b1;
    holdLevel(1'b0, 5);

    for (int i = 0; i < 8; i++) begin
      runVector(vecs[i]);
    end

    $display("[TB] one-space of 36 ticks");
    sel = 0;
    holdLevel(1'b1, 160);
    holdLevel(1'b0, 80);
    holdLevel(1'b1, 10);
    holdLevel(1'b0, 36);
    irMark = 1'b1;
    checkLatency(0, EXP_ERR, 3, "oneSpace36");
    checkOutput("oneSpace36 code", codeV[0], 32'h00FF00FF);
    holdLevel(1'b1, 10);
    holdLevel(1'b0, 20);

    $display("[TB] leader mark of 143 ticks");
    holdLevel(1'b1, 143);
    irMark = 1'b0;
    checkLatency(0, EXP_ERR, 3, "ldr143");
    checkOutput("ldr143 code", codeV[0], 32'h00FF00FF);
    holdLevel(1'b0, 20);

    $display("[TB] line stuck in space after bit 12");
    v = vecs[1];
    holdLevel(1'b1, 160);
    holdLevel(1'b0, 80);
    for (int i = 0; i < 12; i++) begin
      holdLevel(1'b1, 10);
      holdLevel(1'b0, v.data[i] ? 30 : 10);
    end
    holdLevel(1'b1, 10);
    irMark = 1'b0;
    checkLatency(0, EXP_ERR, 3 + TD * 200 + 1, "timeout");
    holdLevel(1'b0, 5);
    runVector(vecs[1]);

    $display("[TB] reset release with line at mark");
    c0 = cvCnt[0];
    irMark = 1'b1;
    reset_N = 1'b0;
    repeat (3) @(negedge clk);
    reset_N = 1'b1;
    holdLevel(1'b1, 3);
    irMark = 1'b0;
    checkLatency(0, EXP_ERR, 3, "markAtReset");
    checkOutput("markAtReset code_valid count", 32'(cvCnt[0] - c0), 32'd0);
    checkOutput("markAtReset code", codeV[0], 32'h0);
    holdLevel(1'b0, 20);

    $display("[TB] reset mid-frame then 16-bit frame");
    runVector(vecs[5]);
    v = vecs[1];
    holdLevel(1'b1, 160);
    holdLevel(1'b0, 80);
    for (int i = 0; i < 20; i++) begin
      holdLevel(1'b1, 10);
      holdLevel(1'b0, v.data[i] ? 30 : 10);
    end
    holdLevel(1'b1, 5);
    checkOutput("midReset busy before", 32'(byV[0]), 32'd1);
    reset_N = 1'b0;
    #1;
    checkOutput("midReset code", codeV[0], 32'h0);
    checkOutput("midReset code_valid", 32'(cvV[0]), 32'd0);
    checkOutput("midReset repeat_valid", 32'(rvV[0]), 32'd0);
    checkOutput("midReset frame_err", 32'(feV[0]), 32'd0);
    checkOutput("midReset busy", 32'(byV[0]), 32'd0);
    checkOutput("midReset n16 code", codeV[2], 32'h0);
    @(negedge clk);
    irMark = 1'b0;
    repeat (3) @(negedge clk);
    reset_N = 1'b1;
    holdLevel(1'b0, 5);
    runVector(mkVec("n16AfterReset", 2, 160, 80, 1'b0, 32'h00005AC3, 16, 10, 10, 30, EXP_CODE, 32'h00005AC3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
